vram_avl_master: RTL and testbench
==================================

VRAM_AVL_MASTER -- requirements
Module: vram_avl_master

Interface
REQ-001 Clk  in  1  system clock; all state changes on rising edge.
REQ-002 RESET  in  1  synchronous, active-high reset; clock Clk.
REQ-003 cmd_valid  in  1  command request from host logic.
REQ-004 cmd_ready  out  1  high only in IDLE; command accepted on edge where cmd_valid & cmd_ready.
REQ-005 cmd_write  in  1  1 = single write, 0 = single read; ignored if cmd_fill=1.
REQ-006 cmd_fill  in  1  1 = block fill (writes only); takes priority over cmd_write.
REQ-007 cmd_addr  in  11  VRAM word address, captured on accept.
REQ-008 cmd_wdata  in  32  write/fill data, captured on accept.
REQ-009 cmd_be  in  4  byte enables for single write, captured on accept.
REQ-010 cmd_count  in  11  fill length in words, captured on accept; 0 legal.
REQ-011 rsp_valid  out  1  one-cycle pulse, read data valid.
REQ-012 rsp_rdata  out  32  read data; holds last value until next read completes.
REQ-013 done  out  1  one-cycle pulse at end of a write or fill.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 AVL_CS, AVL_READ, AVL_WRITE  out  1 each  Avalon-MM master strobes to VRAM responder.
REQ-016 AVL_ADDR  out  11; AVL_BYTE_EN  out  4; AVL_WRITEDATA  out  32; AVL_READDATA  in  32.

Function
REQ-017 The block SHALL implement states IDLE, RD1, RD2, RSP, WR, GAP; all outputs decoded from registered state/registers only.
REQ-018 IDLE: on accept, fill -> WR (or GAP if cmd_count=0); write -> WR; read -> RD1; else stay.
REQ-019 RD1 -> RD2 -> RSP unconditionally; AVL_READ=AVL_CS=1, AVL_BYTE_EN=4'hF in RD1 and RD2 (one wait state).
REQ-020 The block SHALL register AVL_READDATA into rsp_rdata on the edge leaving RD2; RSP drives rsp_valid=1 for one cycle, then -> IDLE.
REQ-021 WR: AVL_WRITE=AVL_CS=1 for exactly one cycle; AVL_BYTE_EN = captured cmd_be for single write, 4'hF for fill; -> GAP.
REQ-022 GAP: all strobes low (lets responder reach its Fetch state); fill with words remaining -> WR with address+1 and remaining-1; otherwise done=1 and -> IDLE.
REQ-023 Fill SHALL issue exactly cmd_count writes of cmd_wdata to consecutive addresses; address wraps 2047 -> 0 (11-bit modulo).
REQ-024 cmd_count=0 fill SHALL produce no bus strobes; IDLE -> GAP (done=1) -> IDLE.
REQ-025 Latency from accept edge N: read rsp_valid in cycle N+3, IDLE at N+4; write WR at N+1, done at N+2, IDLE at N+3; fill of k>=1 done at N+2k.
REQ-026 AVL_READ and AVL_WRITE SHALL never be high in the same cycle; AVL_CS = AVL_READ | AVL_WRITE.
REQ-027 cmd_valid while not IDLE SHALL be ignored (no capture, no queuing).
REQ-028 AVL_ADDR/AVL_WRITEDATA SHALL be stable for every cycle a strobe is high.

Reset
REQ-029 While RESET sampled high: state -> IDLE; cmd_ready=1 after edge; busy, rsp_valid, done, AVL_* strobes = 0; AVL_ADDR=0, AVL_BYTE_EN=0, AVL_WRITEDATA=0, rsp_rdata=0, fill counter=0.
REQ-030 RESET mid-operation SHALL abort immediately: strobes low in the cycle after the reset edge, no rsp_valid or done for the aborted command.
REQ-031 RESET SHALL take priority over cmd_valid on the same edge.

Verification
REQ-032 Read: accept addr=0x005, responder returns 0x4142_4344 during RD2 -> AVL_READ high 2 cycles, rsp_valid at N+3, rsp_rdata=0x41424344.
REQ-033 Write: addr=0x010, wdata=0xDEAD_BEEF, be=4'b0011 -> one AVL_WRITE cycle with those values, done at N+2, IDLE at N+3.
REQ-034 Fill: addr=0x7FE, count=4, wdata=0x2020_2020 -> writes at 0x7FE,0x7FF,0x000,0x001, strobes alternate 1/0, done at N+8.
REQ-035 Fill count=0 -> no strobes, done at N+1, cmd_ready back high at N+2.
REQ-036 Reset during third word of a 10-word fill -> strobes 0 next cycle, no done, next read command completes normally.
REQ-037 cmd_valid held high across a read -> second command accepted only in IDLE at N+4; cmd_fill=cmd_write=1 treated as fill.

Source files
------------

// File: rtl/vram_avl_master.sv
// Avalon-MM master that turns host read / write / block-fill commands into
// single-word VRAM bus cycles, with one wait state on reads and a gap cycle after every write.
module vram_avl_master (
    input  logic        Clk,
    input  logic        RESET,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic        cmd_fill,
    input  logic [10:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_be,
    input  logic [10:0] cmd_count,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        done,
    output logic        busy,
    output logic        AVL_CS,
    output logic        AVL_READ,
    output logic        AVL_WRITE,
    output logic [10:0] AVL_ADDR,
    output logic [3:0]  AVL_BYTE_EN,
    output logic [31:0] AVL_WRITEDATA,
    input  logic [31:0] AVL_READDATA
);

    // state | meaning
    // IDLE  | ready for a command
    // RD1   | read strobe, first cycle
    // RD2   | read strobe, wait state; read data sampled on exit
    // RSP   | rsp_valid pulse
    // WR    | single write strobe
    // GAP   | strobes low; next fill word or done
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] RD1  = 3'd1;
    localparam logic [2:0] RD2  = 3'd2;
    localparam logic [2:0] RSP  = 3'd3;
    localparam logic [2:0] WR   = 3'd4;
    localparam logic [2:0] GAP  = 3'd5;

    logic [2:0]  state;
    logic [10:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic [10:0] remaining_q;

    always_ff @(posedge Clk) begin
        if (RESET) begin
            state       <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            remaining_q <= '0;
            rsp_rdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        addr_q  <= cmd_addr;
                        wdata_q <= cmd_wdata;
                        if (cmd_fill) begin
                            be_q <= 4'hF;
                            // remaining counts the words still owed after the one about to be written
                            if (cmd_count == 11'd0) begin
                                remaining_q <= '0;
                                state       <= GAP;
                            end else begin
                                remaining_q <= cmd_count - 11'd1;
                                state       <= WR;
                            end
                        end else if (cmd_write) begin
                            be_q        <= cmd_be;
                            remaining_q <= '0;
                            state       <= WR;
                        end else begin
                            be_q        <= cmd_be;
                            remaining_q <= '0;
                            state       <= RD1;
                        end
                    end
                end
                RD1: state <= RD2;
                RD2: begin
                    rsp_rdata <= AVL_READDATA;
                    state     <= RSP;
                end
                RSP: state <= IDLE;
                WR:  state <= GAP;
                GAP: begin
                    if (remaining_q != 11'd0) begin
                        addr_q      <= addr_q + 11'd1;
                        remaining_q <= remaining_q - 11'd1;
                        state       <= WR;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        cmd_ready     = (state == IDLE);
        busy          = (state != IDLE);
        rsp_valid     = (state == RSP);
        done          = (state == GAP) && (remaining_q == 11'd0);
        AVL_READ      = (state == RD1) || (state == RD2);
        AVL_WRITE     = (state == WR);
        AVL_CS        = AVL_READ | AVL_WRITE;
        AVL_ADDR      = addr_q;
        AVL_WRITEDATA = wdata_q;
        AVL_BYTE_EN   = 4'h0;
        if (AVL_READ)
            AVL_BYTE_EN = 4'hF;
        else if (AVL_WRITE)
            AVL_BYTE_EN = be_q;
    end

endmodule

// File: tb/tb_vram_avl_master.sv
// Bench for vram_avl_master: per-cycle vector table plus hand-written
// sequences for fill wrap, reset abort and back-to-back commands.
module tb_vram_avl_master;

    logic        Clk = 1'b0;
    logic        RESET;
    logic        cmd_valid, cmd_ready, cmd_write, cmd_fill;
    logic [10:0] cmd_addr, cmd_count;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_be;
    logic        rsp_valid, done, busy;
    logic [31:0] rsp_rdata;
    logic        AVL_CS, AVL_READ, AVL_WRITE;
    logic [10:0] AVL_ADDR;
    logic [3:0]  AVL_BYTE_EN;
    logic [31:0] AVL_WRITEDATA, AVL_READDATA;

    int n_checks = 0;
    int n_fail   = 0;
    logic mon_en = 1'b0;

    always #5 Clk = ~Clk;

    vram_avl_master dut (
        .Clk(Clk), .RESET(RESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_fill(cmd_fill),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .cmd_be(cmd_be), .cmd_count(cmd_count),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .done(done), .busy(busy),
        .AVL_CS(AVL_CS), .AVL_READ(AVL_READ), .AVL_WRITE(AVL_WRITE),
        .AVL_ADDR(AVL_ADDR), .AVL_BYTE_EN(AVL_BYTE_EN),
        .AVL_WRITEDATA(AVL_WRITEDATA), .AVL_READDATA(AVL_READDATA)
    );

    // {cmd_ready, busy, rsp_valid, done, AVL_CS, AVL_READ, AVL_WRITE}
    localparam logic [6:0] C_IDLE = 7'b1000000;
    localparam logic [6:0] C_RD   = 7'b0100110;
    localparam logic [6:0] C_RSP  = 7'b0110000;
    localparam logic [6:0] C_WR   = 7'b0100101;
    localparam logic [6:0] C_GAPD = 7'b0101000;
    localparam logic [6:0] C_GAP  = 7'b0100000;

    typedef struct {
        logic        rst, v, wr, fl;
        logic [10:0] addr;
        logic [31:0] wd;
        logic [3:0]  be;
        logic [10:0] cnt;
        logic [31:0] rd;
        logic [6:0]  e_ctl;
        logic [10:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wd;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(logic rst, logic v, logic wr, logic fl, logic [10:0] addr,
                                logic [31:0] wd, logic [3:0] be, logic [10:0] cnt, logic [31:0] rd,
                                logic [6:0] e_ctl, logic [10:0] e_addr, logic [3:0] e_be,
                                logic [31:0] e_wd, logic [31:0] e_rdata);
        vec_t t;
        t.rst = rst; t.v = v; t.wr = wr; t.fl = fl; t.addr = addr; t.wd = wd;
        t.be = be; t.cnt = cnt; t.rd = rd; t.e_ctl = e_ctl; t.e_addr = e_addr;
        t.e_be = e_be; t.e_wd = e_wd; t.e_rdata = e_rdata;
        return t;
    endfunction

    function automatic logic [6:0] ctl();
        return {cmd_ready, busy, rsp_valid, done, AVL_CS, AVL_READ, AVL_WRITE};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, input logic v, input logic wr, input logic fl,
                         input logic [10:0] addr, input logic [31:0] wd, input logic [3:0] be,
                         input logic [10:0] cnt);
        RESET = rst; cmd_valid = v; cmd_write = wr; cmd_fill = fl;
        cmd_addr = addr; cmd_wdata = wd; cmd_be = be; cmd_count = cnt;
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_in();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 11'd0, 32'd0, 4'd0, 11'd0);
    endtask

    // bus protocol invariants, every cycle
    always @(negedge Clk) begin
        if (mon_en) begin
            chk("rd_wr_exclusive", {63'd0, AVL_READ & AVL_WRITE}, 64'd0);
            chk("cs_is_or", {63'd0, AVL_CS}, {63'd0, AVL_READ | AVL_WRITE});
        end
    end

    initial begin
        logic [10:0] ea;
        vecs[0]  = mk(1,0,0,0,11'h000,32'h0,4'h0,11'd0,32'h0,         C_IDLE,11'h000,4'h0,32'h0,32'h0);
        vecs[1]  = mk(1,1,0,0,11'h005,32'h99,4'h0,11'd0,32'h0,        C_IDLE,11'h000,4'h0,32'h0,32'h0);
        vecs[2]  = mk(0,1,0,0,11'h005,32'h11111111,4'h3,11'd0,32'h0,  C_RD,  11'h005,4'hF,32'h11111111,32'h0);
        vecs[3]  = mk(0,0,0,0,11'h000,32'h0,4'h0,11'd0,32'hBAD0BAD0,  C_RD,  11'h005,4'hF,32'h11111111,32'h0);
        vecs[4]  = mk(0,0,0,0,11'h000,32'h0,4'h0,11'd0,32'h41424344,  C_RSP, 11'h005,4'h0,32'h11111111,32'h41424344);
        vecs[5]  = mk(0,0,0,0,11'h000,32'h0,4'h0,11'd0,32'h0,         C_IDLE,11'h005,4'h0,32'h11111111,32'h41424344);
        vecs[6]  = mk(0,1,1,0,11'h010,32'hDEADBEEF,4'h3,11'd0,32'h0,  C_WR,  11'h010,4'h3,32'hDEADBEEF,32'h41424344);
        vecs[7]  = mk(0,1,0,0,11'h123,32'h0,4'h0,11'd0,32'h0,         C_GAPD,11'h010,4'h0,32'hDEADBEEF,32'h41424344);
        vecs[8]  = mk(0,1,0,0,11'h123,32'h0,4'h0,11'd0,32'h0,         C_IDLE,11'h010,4'h0,32'hDEADBEEF,32'h41424344);
        vecs[9]  = mk(0,1,0,1,11'h300,32'h55AA55AA,4'h0,11'd0,32'h0,  C_GAPD,11'h300,4'h0,32'h55AA55AA,32'h41424344);
        vecs[10] = mk(0,0,0,0,11'h000,32'h0,4'h0,11'd0,32'h0,         C_IDLE,11'h300,4'h0,32'h55AA55AA,32'h41424344);
        vecs[11] = mk(0,1,1,1,11'h7FF,32'h0F0F0F0F,4'h0,11'd1,32'h0,  C_WR,  11'h7FF,4'hF,32'h0F0F0F0F,32'h41424344);
        vecs[12] = mk(0,0,0,0,11'h000,32'h0,4'h0,11'd0,32'h0,         C_GAPD,11'h7FF,4'h0,32'h0F0F0F0F,32'h41424344);
        vecs[13] = mk(0,0,0,0,11'h000,32'h0,4'h0,11'd0,32'h0,         C_IDLE,11'h7FF,4'h0,32'h0F0F0F0F,32'h41424344);
        vecs[14] = mk(0,1,1,0,11'h020,32'hCAFEF00D,4'h1,11'd5,32'h0,  C_WR,  11'h020,4'h1,32'hCAFEF00D,32'h41424344);
        vecs[15] = mk(1,0,0,0,11'h000,32'h0,4'h0,11'd0,32'h0,         C_IDLE,11'h000,4'h0,32'h0,32'h0);

        AVL_READDATA = 32'h0;
        idle_in();
        RESET = 1'b1;

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].rst, vecs[i].v, vecs[i].wr, vecs[i].fl, vecs[i].addr,
                  vecs[i].wd, vecs[i].be, vecs[i].cnt);
            AVL_READDATA = vecs[i].rd;
            step();
            mon_en = 1'b1;
            chk($sformatf("vec%0d_ctl", i),   {57'd0, ctl()},         {57'd0, vecs[i].e_ctl});
            chk($sformatf("vec%0d_addr", i),  {53'd0, AVL_ADDR},      {53'd0, vecs[i].e_addr});
            chk($sformatf("vec%0d_be", i),    {60'd0, AVL_BYTE_EN},   {60'd0, vecs[i].e_be});
            chk($sformatf("vec%0d_wdata", i), {32'd0, AVL_WRITEDATA}, {32'd0, vecs[i].e_wd});
            chk($sformatf("vec%0d_rdata", i), {32'd0, rsp_rdata},     {32'd0, vecs[i].e_rdata});
        end

        // fill of 4 words wrapping 0x7FE -> 0x001
        drive(1'b0, 1'b1, 1'b0, 1'b1, 11'h7FE, 32'h20202020, 4'h0, 11'd4);
        step();
        idle_in();
        for (int k = 1; k <= 8; k++) begin
            ea = 11'h7FE + 11'((k - 1) / 2);
            if (k % 2 == 1) begin
                chk($sformatf("fill4_c%0d_ctl", k), {57'd0, ctl()}, {57'd0, C_WR});
                chk($sformatf("fill4_c%0d_be", k), {60'd0, AVL_BYTE_EN}, 64'hF);
                chk($sformatf("fill4_c%0d_wd", k), {32'd0, AVL_WRITEDATA}, 64'h20202020);
            end else begin
                chk($sformatf("fill4_c%0d_ctl", k), {57'd0, ctl()}, {57'd0, (k == 8) ? C_GAPD : C_GAP});
            end
            chk($sformatf("fill4_c%0d_addr", k), {53'd0, AVL_ADDR}, {53'd0, ea});
            if (k < 8) step();
        end
        step();
        chk("fill4_idle", {57'd0, ctl()}, {57'd0, C_IDLE});

        // reset during third word of a 10-word fill
        drive(1'b0, 1'b1, 1'b0, 1'b1, 11'h100, 32'hA5A5A5A5, 4'h0, 11'd10);
        step();
        idle_in();
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("fill10_c%0d_ctl", k), {57'd0, ctl()}, {57'd0, (k % 2 == 1) ? C_WR : C_GAP});
            step();
        end
        chk("fill10_w3_ctl", {57'd0, ctl()}, {57'd0, C_WR});
        chk("fill10_w3_addr", {53'd0, AVL_ADDR}, 64'h102);
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        chk("abort_ctl", {57'd0, ctl()}, {57'd0, C_IDLE});
        chk("abort_addr", {53'd0, AVL_ADDR}, 64'h0);
        for (int k = 0; k < 12; k++) begin
            step();
            chk($sformatf("abort_quiet%0d", k), {57'd0, ctl()}, {57'd0, C_IDLE});
        end
        AVL_READDATA = 32'h12345678;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 11'h00A, 32'h0, 4'h0, 11'd0);
        step();
        idle_in();
        chk("post_rd1", {57'd0, ctl()}, {57'd0, C_RD});
        step();
        chk("post_rd2", {57'd0, ctl()}, {57'd0, C_RD});
        step();
        chk("post_rsp", {57'd0, ctl()}, {57'd0, C_RSP});
        chk("post_rdata", {32'd0, rsp_rdata}, 64'h12345678);
        step();
        chk("post_idle", {57'd0, ctl()}, {57'd0, C_IDLE});

        // cmd_valid held across a read: next accept only from IDLE at N+4
        AVL_READDATA = 32'h0BADF00D;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 11'h001, 32'h0, 4'h0, 11'd0);
        step();
        cmd_addr = 11'h002;
        for (int k = 1; k <= 3; k++) begin
            chk($sformatf("hold_c%0d_ctl", k), {57'd0, ctl()}, {57'd0, (k == 3) ? C_RSP : C_RD});
            chk($sformatf("hold_c%0d_addr", k), {53'd0, AVL_ADDR}, 64'h001);
            step();
        end
        chk("hold_n4_ctl", {57'd0, ctl()}, {57'd0, C_IDLE});
        step();
        idle_in();
        chk("hold_n5_ctl", {57'd0, ctl()}, {57'd0, C_RD});
        chk("hold_n5_addr", {53'd0, AVL_ADDR}, 64'h002);
        step(); step(); step();
        chk("hold_end_ctl", {57'd0, ctl()}, {57'd0, C_IDLE});
        chk("hold_end_rdata", {32'd0, rsp_rdata}, 64'h0BADF00D);

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
